// File: rtl/div_6by3_seq.sv
// div_6by3_seq: iterative restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional DIV_ZERO_ERR_EN: flag divide-by-zero and finish one cycle after accept.
module div_6by3_seq #(
  parameter int DW = 6,
  parameter int VW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero
);
  localparam int CW = $clog2(DW + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [DW-1:0] dvd, dvd_n, quotient_n;
  logic [VW-1:0] dvs, dvs_n, r, r_n, remainder_n;
  logic [VW:0] trial;
  logic [CW-1:0] cnt, cnt_n;
  logic busy_n, done_n, div_zero_n, ge, zero;
  assign trial = {r, dvd[DW-1]};
  assign ge = trial >= {1'b0, dvs};
`ifdef DIV_ZERO_ERR_EN
  assign zero = dvs == '0;
`else
  assign zero = 1'b0;
`endif
  always_comb begin
    state_n = state;
    dvd_n = dvd;
    dvs_n = dvs;
    r_n = r;
    cnt_n = cnt;
    busy_n = busy;
    done_n = 1'b0;
    div_zero_n = div_zero;
    quotient_n = quotient;
    remainder_n = remainder;
    if (state == RUN) begin
      r_n = ge ? VW'(trial - {1'b0, dvs}) : trial[VW-1:0];
      dvd_n = {dvd[DW-2:0], ge};
      cnt_n = cnt + 1'b1;
      if (zero || cnt == CW'(DW - 1)) begin
        state_n = DONE;
        busy_n = 1'b0;
        done_n = 1'b1;
        cnt_n = '0;
        div_zero_n = zero;
        quotient_n = zero ? '1 : dvd_n;
        remainder_n = zero ? dvd[VW-1:0] : r_n;
      end
    end else if (start) begin
      state_n = RUN;
      dvd_n = dividend;
      dvs_n = divisor;
      r_n = '0;
      cnt_n = '0;
      busy_n = 1'b1;
      div_zero_n = 1'b0;
    end else begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      dvd <= '0;
      dvs <= '0;
      r <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      div_zero <= 1'b0;
      quotient <= '0;
      remainder <= '0;
    end else begin
      state <= state_n;
      dvd <= dvd_n;
      dvs <= dvs_n;
      r <= r_n;
      cnt <= cnt_n;
      busy <= busy_n;
      done <= done_n;
      div_zero <= div_zero_n;
      quotient <= quotient_n;
      remainder <= remainder_n;
    end
  end
endmodule
